// File: rtl/multicycle_control_pkg.sv
// multicycle_control_pkg: shared opcodes, funct codes, ALU codes, states and control decode
package multicycle_control_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] F_ADD = 6'h20;
    localparam logic [5:0] F_SUB = 6'h22;
    localparam logic [5:0] F_AND = 6'h24;
    localparam logic [5:0] F_OR  = 6'h25;
    localparam logic [5:0] F_XOR = 6'h26;
    localparam logic [5:0] F_NOR = 6'h27;
    localparam logic [5:0] F_SLT = 6'h2A;

    typedef enum logic [2:0] {
        ALU_AND   = 3'd0,
        ALU_OR    = 3'd1,
        ALU_ADD   = 3'd2,
        ALU_XOR   = 3'd3,
        ALU_NOR   = 3'd4,
        ALU_ERROR = 3'd5,
        ALU_SUB   = 3'd6,
        ALU_SLT   = 3'd7
    } alu_t;

    typedef enum logic [3:0] {
        S_START, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
        S_RTEX, S_RTWB, S_BEQEX, S_ADDIEX, S_ADDIWB, S_JEX, S_ERR
    } state_t;

    typedef struct packed {
        logic       iord;
        logic       mem_write;
        logic       reg_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_src;
        alu_t       alu_ctl;
    } ctl_t;

    // Moore controls for a state; anything not named is 0 and the ALU defaults to ADD
    function automatic ctl_t ctl_of(state_t s, alu_t rt);
        ctl_t c;
        c = '0;
        c.alu_ctl = ALU_ADD;
        case (s)
            S_FETCH:            c.alu_src_b = 2'd1;
            S_DECODE:           c.alu_src_b = 2'd3;
            S_MEMADR, S_ADDIEX: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'd2; end
            S_MEMRD:            c.iord = 1'b1;
            S_MEMWR:            begin c.iord = 1'b1; c.mem_write = 1'b1; end
            S_MEMWB:            begin c.reg_write = 1'b1; c.mem_to_reg = 1'b1; end
            S_ADDIWB:           c.reg_write = 1'b1;
            S_RTEX:             begin c.alu_src_a = 1'b1; c.alu_ctl = rt; end
            S_RTWB:             begin c.reg_write = 1'b1; c.reg_dst = 1'b1; end
            S_BEQEX:            begin c.alu_src_a = 1'b1; c.alu_ctl = ALU_SUB; c.pc_src = 2'd1; end
            S_JEX:              c.pc_src = 2'd2;
            default:            ;
        endcase
        return c;
    endfunction

endpackage

// File: rtl/multicycle_control_alu_ctl.sv
// multicycle_control_alu_ctl: R-type funct to ALU operation, ALU_ERROR for unknown funct
module multicycle_control_alu_ctl
    import multicycle_control_pkg::*;
(
    input  logic [5:0] funct,
    output alu_t       alu_ctl
);

    // priority-free lookup; anything outside the supported set maps to ALU_ERROR
    always_comb
        alu_ctl = funct == F_ADD ? ALU_ADD :
                  funct == F_SUB ? ALU_SUB :
                  funct == F_AND ? ALU_AND :
                  funct == F_OR  ? ALU_OR  :
                  funct == F_XOR ? ALU_XOR :
                  funct == F_NOR ? ALU_NOR :
                  funct == F_SLT ? ALU_SLT : ALU_ERROR;

endmodule

// File: rtl/multicycle_control.sv
// multicycle_control: multicycle MIPS-subset control FSM with registered Moore outputs
module multicycle_control
    import multicycle_control_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic [5:0] funct,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       pc_en,
    output logic       iord,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_src,
    output logic [2:0] alu_ctl,
    output logic       illegal
);

    state_t state, nxt;
    alu_t   rt_ctl;
    ctl_t   ctl;

    multicycle_control_alu_ctl u_alu_ctl (.funct(funct), .alu_ctl(rt_ctl));

    // next-state selection from the current state and decoded instruction fields
    always_comb begin
        nxt = state;
        case (state)
            S_START:  nxt = S_FETCH;
            S_FETCH:  nxt = mem_ready ? S_DECODE : S_FETCH;
            S_DECODE: nxt = (opcode == OP_LW || opcode == OP_SW) ? S_MEMADR :
                            opcode == OP_RTYPE ? S_RTEX   :
                            opcode == OP_BEQ   ? S_BEQEX  :
                            opcode == OP_ADDI  ? S_ADDIEX :
                            opcode == OP_J     ? S_JEX    : S_ERR;
            S_MEMADR: nxt = opcode == OP_LW ? S_MEMRD : S_MEMWR;
            S_MEMRD:  nxt = mem_ready ? S_MEMWB : S_MEMRD;
            S_MEMWR:  nxt = mem_ready ? S_FETCH : S_MEMWR;
            S_RTEX:   nxt = rt_ctl == ALU_ERROR ? S_ERR : S_RTWB;
            S_ADDIEX: nxt = S_ADDIWB;
            S_ERR:    nxt = S_ERR;
            default:  nxt = S_FETCH;
        endcase
    end

    // state plus controls precomputed for the state being entered, so outputs come straight from flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= S_START;
            ctl     <= ctl_of(S_START, ALU_ADD);
            illegal <= 1'b0;
        end else begin
            state   <= nxt;
            ctl     <= ctl_of(nxt, rt_ctl);
            illegal <= illegal | (nxt == S_ERR);
        end
    end

    // fetch handshake and branch qualification must react to inputs within the cycle
    assign ir_write   = state == S_FETCH && mem_ready;
    assign pc_en      = ir_write || (state == S_BEQEX && zero) || state == S_JEX;
    assign iord       = ctl.iord;
    assign mem_write  = ctl.mem_write;
    assign reg_write  = ctl.reg_write;
    assign reg_dst    = ctl.reg_dst;
    assign mem_to_reg = ctl.mem_to_reg;
    assign alu_src_a  = ctl.alu_src_a;
    assign alu_src_b  = ctl.alu_src_b;
    assign pc_src     = ctl.pc_src;
    assign alu_ctl    = ctl.alu_ctl;

endmodule

// File: tb/tb_multicycle_control.sv
// tb_multicycle_control: directed walk through every instruction class, errors and resets
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    logic       clk, reset, zero, mem_ready;
    logic [5:0] opcode, funct;
    logic       pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg, alu_src_a, illegal;
    logic [1:0] alu_src_b, pc_src;
    logic [2:0] alu_ctl;
    int         checks = 0;
    int         errors = 0;

    multicycle_control dut (
        .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
        .mem_ready(mem_ready), .pc_en(pc_en), .iord(iord), .mem_write(mem_write),
        .ir_write(ir_write), .reg_write(reg_write), .reg_dst(reg_dst),
        .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .pc_src(pc_src), .alu_ctl(alu_ctl), .illegal(illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wire [15:0] obs = {pc_en, iord, mem_write, ir_write, reg_write, reg_dst, mem_to_reg,
                       alu_src_a, alu_src_b, pc_src, alu_ctl, illegal};

    // expected output vector, same field order as obs
    function automatic logic [15:0] e(bit p, bit i, bit w, bit ir, bit rw, bit rd, bit mr, bit a,
                                      logic [1:0] b, logic [1:0] s, logic [2:0] c, bit il);
        return {p, i, w, ir, rw, rd, mr, a, b, s, c, il};
    endfunction

    task automatic chk(input string tag, input logic [15:0] x);
        checks++;
        assert (obs === x) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, x);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1; opcode = OP_RTYPE; funct = 6'h20; zero = 1'b0; mem_ready = 1'b1;
        step();
        chk("reset", e(0,0,0,0,0,0,0,0,0,0,ALU_ADD,0));
        reset = 1'b0;
        chk("start_after_reset", e(0,0,0,0,0,0,0,0,0,0,ALU_ADD,0));
        step(); chk("add_fetch",  e(1,0,0,1,0,0,0,0,1,0,ALU_ADD,0));
        step(); chk("add_decode", e(0,0,0,0,0,0,0,0,3,0,ALU_ADD,0));
        step(); chk("add_rtex",   e(0,0,0,0,0,0,0,1,0,0,ALU_ADD,0));
        step(); chk("add_rtwb",   e(0,0,0,0,1,1,0,0,0,0,ALU_ADD,0));
        step(); chk("add_fetch2", e(1,0,0,1,0,0,0,0,1,0,ALU_ADD,0));
        // lw with three wait cycles in MEMRD
        opcode = OP_LW;
        step(); chk("lw_decode", e(0,0,0,0,0,0,0,0,3,0,ALU_ADD,0));
        step(); chk("lw_memadr", e(0,0,0,0,0,0,0,1,2,0,ALU_ADD,0));
        mem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(); chk($sformatf("lw_memrd%0d", i), e(0,1,0,0,0,0,0,0,0,0,ALU_ADD,0));
        end
        mem_ready = 1'b1;
        step(); chk("lw_memwb", e(0,0,0,0,1,0,1,0,0,0,ALU_ADD,0));
        step(); chk("lw_fetch", e(1,0,0,1,0,0,0,0,1,0,ALU_ADD,0));
        // fetch stall then release
        mem_ready = 1'b0;
        opcode = OP_BEQ; zero = 1'b1;
        step(); chk("fetch_stall", e(0,0,0,0,0,0,0,0,1,0,ALU_ADD,0));
        mem_ready = 1'b1;
        #1; chk("fetch_ready", e(1,0,0,1,0,0,0,0,1,0,ALU_ADD,0));
        step(); chk("beq_decode", e(0,0,0,0,0,0,0,0,3,0,ALU_ADD,0));
        step(); chk("beq_taken",  e(1,0,0,0,0,0,0,1,0,1,ALU_SUB,0));
        step(); chk("beq_fetch",  e(1,0,0,1,0,0,0,0,1,0,ALU_ADD,0));
        zero = 1'b0;
        step();
        step(); chk("beq_not_taken", e(0,0,0,0,0,0,0,1,0,1,ALU_SUB,0));
        step();
        // jump
        opcode = OP_J;
        step();
        step(); chk("j_jex",   e(1,0,0,0,0,0,0,0,0,2,ALU_ADD,0));
        step(); chk("j_fetch", e(1,0,0,1,0,0,0,0,1,0,ALU_ADD,0));
        // addi
        opcode = OP_ADDI;
        step();
        step(); chk("addi_ex", e(0,0,0,0,0,0,0,1,2,0,ALU_ADD,0));
        step(); chk("addi_wb", e(0,0,0,0,1,0,0,0,0,0,ALU_ADD,0));
        step();
        // sw completing immediately
        opcode = OP_SW;
        step();
        step(); chk("sw_memadr", e(0,0,0,0,0,0,0,1,2,0,ALU_ADD,0));
        step(); chk("sw_memwr",  e(0,1,1,0,0,0,0,0,0,0,ALU_ADD,0));
        step(); chk("sw_fetch",  e(1,0,0,1,0,0,0,0,1,0,ALU_ADD,0));
        // R-type AND
        opcode = OP_RTYPE; funct = 6'h24;
        step();
        step(); chk("and_rtex", e(0,0,0,0,0,0,0,1,0,0,ALU_AND,0));
        step(); chk("and_rtwb", e(0,0,0,0,1,1,0,0,0,0,ALU_ADD,0));
        step();
        // undecodable opcode
        opcode = 6'h3F;
        step();
        step(); chk("op_err", e(0,0,0,0,0,0,0,0,0,0,ALU_ADD,1));
        zero = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(); chk($sformatf("op_err_hold%0d", i), e(0,0,0,0,0,0,0,0,0,0,ALU_ADD,1));
        end
        zero = 1'b0;
        #3 reset = 1'b1;
        #1 chk("async_reset_clears_illegal", e(0,0,0,0,0,0,0,0,0,0,ALU_ADD,0));
        step();
        reset = 1'b0;
        // undecodable funct
        opcode = OP_RTYPE; funct = 6'h18;
        step(); chk("funct_fetch", e(1,0,0,1,0,0,0,0,1,0,ALU_ADD,0));
        step();
        step(); chk("funct_rtex", e(0,0,0,0,0,0,0,1,0,0,ALU_ERROR,0));
        step(); chk("funct_err",  e(0,0,0,0,0,0,0,0,0,0,ALU_ADD,1));
        step(); chk("funct_err_hold", e(0,0,0,0,0,0,0,0,0,0,ALU_ADD,1));
        #3 reset = 1'b1;
        step();
        reset = 1'b0;
        // reset in the middle of a stalled store
        opcode = OP_SW;
        step();
        step();
        step();
        mem_ready = 1'b0;
        step(); chk("sw_stall0", e(0,1,1,0,0,0,0,0,0,0,ALU_ADD,0));
        step(); chk("sw_stall1", e(0,1,1,0,0,0,0,0,0,0,ALU_ADD,0));
        #3 reset = 1'b1;
        #1 chk("sw_reset_drop", e(0,0,0,0,0,0,0,0,0,0,ALU_ADD,0));
        step();
        reset = 1'b0;
        mem_ready = 1'b1;
        chk("sw_reset_start", e(0,0,0,0,0,0,0,0,0,0,ALU_ADD,0));
        step(); chk("sw_reset_fetch", e(1,0,0,1,0,0,0,0,1,0,ALU_ADD,0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
